odma_ddr_rd_arbiter: RTL

//  Shares one DDR AXI4 read port (AR+R) between NUM_REQ read requesters, e.g. the host-DMA path and an action engine.

---
 rtl/odma_arb_pkg.sv | 20 ++
 rtl/odma_rr_arbiter.sv | 31 +++
 rtl/odma_ddr_rd_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/odma_arb_pkg.sv
// Shared AXI constants and a constant-foldable clog2 for the DDR read arbiter.
// Safe to call when sizing parameters and localparams.
package odma_arb_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/odma_rr_arbiter.sv
// Mask-based round-robin arbiter with a one-hot grant.
// The mask keeps only requesters after the last winner; when that leaves nobody, the plain request vector is used.
module odma_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    logic [N-1:0] mask_reg;
    logic [N-1:0] masked;
    logic [N-1:0] pick;

    assign masked = req & mask_reg;
    assign pick   = (|masked) ? masked : req;
    // Isolate the lowest set bit.
    assign gnt    = pick & (~pick + N'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_reg <= '1;
        end else if (advance) begin
            // Keep only the bits strictly above the winner.
            mask_reg <= ~(gnt | (gnt - N'(1)));
        end
    end

endmodule

// File: rtl/odma_ddr_rd_arbiter.sv
// Shares one DDR AXI4 read port between NUM_REQ requesters.
// Round-robin AR issue with a per-requester outstanding cap; R beats are steered back by rid.
module odma_ddr_rd_arbiter
    import odma_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 33,
    parameter int DATA_W   = 512,
    parameter int ID_W     = 4,
    parameter int MAX_OUTS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        s_arvalid,
    output logic [NUM_REQ-1:0]        s_arready,
    input  logic [NUM_REQ*ADDR_W-1:0] s_araddr,
    input  logic [NUM_REQ*8-1:0]      s_arlen,
    output logic [NUM_REQ-1:0]        s_rvalid,
    input  logic [NUM_REQ-1:0]        s_rready,
    output logic [DATA_W-1:0]         s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rlast,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [ADDR_W-1:0]         m_araddr,
    output logic [7:0]                m_arlen,
    output logic [ID_W-1:0]           m_arid,
    output logic [2:0]                m_arsize,
    output logic [1:0]                m_arburst,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    input  logic [ID_W-1:0]           m_rid,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rlast,
    output logic                      busy,
    output logic                      err_rid
);

    localparam int CNT_W = clog2(MAX_OUTS + 1);
    localparam int IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;

    logic [CNT_W-1:0]   outs_reg [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] outs_nz;
    logic [NUM_REQ-1:0] rid_hit;
    logic [IDX_W-1:0]   win_idx;
    logic               load;
    logic               advance;
    logic               r_beat_last;

    assign load    = !m_arvalid || m_arready;
    // Grants are masked while reset is held so nothing is accepted that the cleared state would lose.
    assign advance = load && (|gnt) && !rst;

    odma_rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (eligible),
        .advance (advance),
        .gnt     (gnt)
    );

    assign s_arready = advance ? gnt : '0;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_idx = win_idx | IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_arvalid <= 1'b0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arid    <= '0;
        end else if (advance) begin
            m_arvalid <= 1'b1;
            m_araddr  <= s_araddr[win_idx*ADDR_W +: ADDR_W];
            m_arlen   <= s_arlen[win_idx*8 +: 8];
            m_arid    <= ID_W'(win_idx);
        end else if (m_arready) begin
            m_arvalid <= 1'b0;
        end
    end

    assign m_arsize    = 3'(clog2(DATA_W / 8));
    assign m_arburst   = AXI_BURST_INCR;
    assign r_beat_last = m_rvalid && m_rready && m_rlast;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic inc;
            logic dec;

            assign rid_hit[gi]  = (m_rid == ID_W'(gi));
            assign s_rvalid[gi] = m_rvalid && rid_hit[gi];
            assign eligible[gi] = s_arvalid[gi] && (outs_reg[gi] < CNT_W'(MAX_OUTS));
            assign outs_nz[gi]  = (outs_reg[gi] != '0);
            assign inc          = s_arvalid[gi] && s_arready[gi];
            assign dec          = r_beat_last && rid_hit[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    outs_reg[gi] <= '0;
                end else if (inc && !dec) begin
                    outs_reg[gi] <= outs_reg[gi] + CNT_W'(1);
                end else if (dec && !inc && outs_nz[gi]) begin
                    outs_reg[gi] <= outs_reg[gi] - CNT_W'(1);
                end
            end
        end
    endgenerate

    // Beats for an unknown ID are drained so the DDR R channel can never lock up.
    assign m_rready = (|rid_hit) ? (|(rid_hit & s_rready)) : 1'b1;
    assign s_rdata  = m_rdata;
    assign s_rresp  = m_rresp;
    assign s_rlast  = m_rlast;
    assign busy     = m_arvalid || (|outs_nz);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_rid <= 1'b0;
        end else if (m_rvalid && !(|rid_hit)) begin
            err_rid <= 1'b1;
        end
    end

endmodule
